// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetchState_t;

  localparam int unsigned INSTR_BYTES       = 4;
  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam int unsigned DEFAULT_MEM_BYTES = 256;

  localparam int unsigned JT_HI_W  = 4;
  localparam int unsigned JT_IDX_W = 26;
  localparam int unsigned JT_LO_W  = 2;

  // J-type target: upper bits of the jump's own PC+4, the index, then word alignment.
  function automatic logic [31:0] jumpTargetOf(input logic [31:0] basePcPlus4,
                                               input logic [JT_IDX_W-1:0] index);
    return {basePcPlus4[31:32-JT_HI_W], index, {JT_LO_W{1'b0}}};
  endfunction

endpackage

// File: rtl/next_pc_select.sv
// Combinational next-PC priority mux (branch > jump > hold > +4) and fetch-address check.
module next_pc_select
  import fetch_pkg::*;
#(
  parameter int unsigned MEM_BYTES = DEFAULT_MEM_BYTES
) (
  input  logic [31:0]         pc,
  input  logic [31:0]         ifidPcPlus4,
  input  logic                branchTaken,
  input  logic [31:0]         branchTarget,
  input  logic                jump,
  input  logic [JT_IDX_W-1:0] jumpIndex,
  input  logic                stall,
  output logic [31:0]         nextPc,
  output logic [31:0]         pcPlus4,
  output logic                pcBad,
  output logic                redirect
);

  localparam logic [31:0] MAX_FETCH = 32'(MEM_BYTES - INSTR_BYTES);

  always_comb begin
    pcPlus4  = pc + 32'(INSTR_BYTES);
    pcBad    = (pc[1:0] != 2'b00) || (pc > MAX_FETCH);
    redirect = branchTaken || jump;
    if (branchTaken)
      nextPc = branchTarget;
    else if (jump)
      nextPc = jumpTargetOf(ifidPcPlus4, jumpIndex);
    else if (pcBad || stall)
      nextPc = pc;
    else
      nextPc = pcPlus4;
  end

endmodule

// File: rtl/pc_fetch_stage.sv
// Instruction-fetch stage: PC register, RUN/FAULT control and the IF/ID pipeline register.
module pc_fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned MEM_BYTES = DEFAULT_MEM_BYTES
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pcOut,
  input  logic [31:0] instrIn,
  input  logic        stall,
  input  logic        flush,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  input  logic        jump,
  input  logic [25:0] jumpIndex,
  output logic [31:0] ifidInstr,
  output logic [31:0] ifidPcPlus4,
  output logic        ifidValid,
  output logic        fault
);

  fetchState_t state;
  logic [31:0] nextPc;
  logic [31:0] pcPlus4;
  logic        pcBad;
  logic        redirect;

  next_pc_select #(
    .MEM_BYTES(MEM_BYTES)
  ) uSel (
    .pc          (pcOut),
    .ifidPcPlus4 (ifidPcPlus4),
    .branchTaken (branchTaken),
    .branchTarget(branchTarget),
    .jump        (jump),
    .jumpIndex   (jumpIndex),
    .stall       (stall),
    .nextPc      (nextPc),
    .pcPlus4     (pcPlus4),
    .pcBad       (pcBad),
    .redirect    (redirect)
  );

  // The mux already resolves the PC for every RUN case; here only IF/ID and the state vary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      pcOut       <= RESET_PC;
      ifidInstr   <= '0;
      ifidPcPlus4 <= '0;
      ifidValid   <= 1'b0;
      fault       <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          pcOut <= nextPc;
          if (redirect || (!redirect && pcBad) || flush) begin
            ifidInstr   <= '0;
            ifidPcPlus4 <= '0;
            ifidValid   <= 1'b0;
            if (!redirect && pcBad) begin
              state <= FAULT;
              fault <= 1'b1;
            end
          end else if (!stall) begin
            ifidInstr   <= instrIn;
            ifidPcPlus4 <= pcPlus4;
            ifidValid   <= 1'b1;
          end
        end
        FAULT: begin
          state <= FAULT;
        end
        default: state <= FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Randomized and directed bench for pc_fetch_stage against a rule-level fetch model.
module tb_pc_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pcOut;
  logic [31:0] instrIn;
  logic        stall, flush, branchTaken, jump;
  logic [31:0] branchTarget;
  logic [25:0] jumpIndex;
  logic [31:0] ifidInstr, ifidPcPlus4;
  logic        ifidValid, fault;

  logic [31:0] mem [0:63];

  int unsigned nVec = 0;
  int unsigned nErr = 0;

  // reference state
  logic [31:0] mPc, mInstr, mPc4;
  logic        mValid, mFault;

  always #5 clk = ~clk;

  assign instrIn = mem[pcOut[7:2]];

  pc_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .MEM_BYTES(256)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pcOut       (pcOut),
    .instrIn     (instrIn),
    .stall       (stall),
    .flush       (flush),
    .branchTaken (branchTaken),
    .branchTarget(branchTarget),
    .jump        (jump),
    .jumpIndex   (jumpIndex),
    .ifidInstr   (ifidInstr),
    .ifidPcPlus4 (ifidPcPlus4),
    .ifidValid   (ifidValid),
    .fault       (fault)
  );

  task automatic clearInputs();
    stall = 0; flush = 0; branchTaken = 0; jump = 0;
    branchTarget = '0; jumpIndex = '0;
  endtask

  task automatic modelReset();
    mPc = 32'h0; mInstr = 32'h0; mPc4 = 32'h0; mValid = 0; mFault = 0;
  endtask

  task automatic modelInvalidate();
    mInstr = 32'h0; mPc4 = 32'h0; mValid = 0;
  endtask

  // One clock edge of the fetch rules, applied in priority order.
  task automatic modelEdge();
    logic bad;
    if (mFault) return;
    bad = (mPc % 4 != 0) || (mPc > 256 - 4);
    if (branchTaken) begin
      mPc = branchTarget; modelInvalidate();
    end else if (jump) begin
      mPc = (mPc4 & 32'hF000_0000) | (32'(jumpIndex) * 4); modelInvalidate();
    end else if (bad) begin
      mFault = 1; modelInvalidate();
    end else if (stall) begin
      if (flush) modelInvalidate();
    end else if (flush) begin
      mPc = mPc + 4; modelInvalidate();
    end else begin
      mInstr = mem[mPc / 4]; mPc4 = mPc + 4; mValid = 1; mPc = mPc + 4;
    end
  endtask

  task automatic applyEdge();
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 0;
    #2;
    clearInputs();
    modelReset();
    rst_n = 1;
  endtask

  task automatic test_reset();
    clearInputs();
    rst_n = 0;
    modelReset();
    #2;
    nVec++; if (pcOut !== 32'h0) begin nErr++; $display("FAIL reset pcOut got %h want 00000000", pcOut); end
    nVec++; if (ifidInstr !== 32'h0) begin nErr++; $display("FAIL reset ifidInstr got %h want 0", ifidInstr); end
    nVec++; if (ifidPcPlus4 !== 32'h0) begin nErr++; $display("FAIL reset ifidPcPlus4 got %h want 0", ifidPcPlus4); end
    nVec++; if (ifidValid !== 1'b0) begin nErr++; $display("FAIL reset ifidValid got %b want 0", ifidValid); end
    nVec++; if (fault !== 1'b0) begin nErr++; $display("FAIL reset fault got %b want 0", fault); end
  endtask

  task automatic test_freerun();
    rst_n = 1;
    applyEdge();
    nVec++; if (ifidInstr !== 32'h2008_0001) begin nErr++; $display("FAIL run1 ifidInstr got %h want 20080001", ifidInstr); end
    nVec++; if (ifidPcPlus4 !== 32'h4) begin nErr++; $display("FAIL run1 ifidPcPlus4 got %h want 4", ifidPcPlus4); end
    nVec++; if (pcOut !== 32'h4) begin nErr++; $display("FAIL run1 pcOut got %h want 4", pcOut); end
    nVec++; if (ifidValid !== 1'b1) begin nErr++; $display("FAIL run1 ifidValid got %b want 1", ifidValid); end
    applyEdge();
    nVec++; if (ifidInstr !== 32'h2009_0002) begin nErr++; $display("FAIL run2 ifidInstr got %h want 20090002", ifidInstr); end
    nVec++; if (ifidPcPlus4 !== 32'h8) begin nErr++; $display("FAIL run2 ifidPcPlus4 got %h want 8", ifidPcPlus4); end
  endtask

  task automatic test_stall();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      applyEdge();
      nVec++; if (pcOut !== 32'h8) begin nErr++; $display("FAIL stall%0d pcOut got %h want 8", i, pcOut); end
      nVec++; if (ifidInstr !== 32'h2009_0002 || ifidPcPlus4 !== 32'h8 || ifidValid !== 1'b1) begin
        nErr++; $display("FAIL stall%0d ifid got %h/%h/%b want 20090002/8/1", i, ifidInstr, ifidPcPlus4, ifidValid);
      end
    end
    stall = 0;
    applyEdge();
    nVec++; if (ifidInstr !== mem[2] || ifidPcPlus4 !== 32'hC) begin
      nErr++; $display("FAIL stall_resume got %h/%h want %h/0000000c", ifidInstr, ifidPcPlus4, mem[2]);
    end
  endtask

  task automatic test_branch();
    stall = 1; branchTaken = 1; branchTarget = 32'h40;
    applyEdge();
    nVec++; if (pcOut !== 32'h40 || ifidValid !== 1'b0) begin
      nErr++; $display("FAIL branch_stall pcOut/valid got %h/%b want 00000040/0", pcOut, ifidValid);
    end
    clearInputs();
    applyEdge();
    nVec++; if (ifidPcPlus4 !== 32'h44 || ifidValid !== 1'b1 || ifidInstr !== mem[16]) begin
      nErr++; $display("FAIL branch_target got %h/%b/%h want 00000044/1/%h", ifidPcPlus4, ifidValid, ifidInstr, mem[16]);
    end
  endtask

  task automatic test_jump();
    doReset();
    applyEdge();
    applyEdge();
    jump = 1; jumpIndex = 26'h000010;
    applyEdge();
    nVec++; if (pcOut !== 32'h40 || ifidValid !== 1'b0) begin
      nErr++; $display("FAIL jump pcOut/valid got %h/%b want 00000040/0", pcOut, ifidValid);
    end
    jump = 1; jumpIndex = 26'h000020; branchTaken = 1; branchTarget = 32'h90;
    applyEdge();
    nVec++; if (pcOut !== 32'h90) begin nErr++; $display("FAIL branch_over_jump pcOut got %h want 00000090", pcOut); end
    clearInputs();
  endtask

  task automatic test_fault();
    branchTaken = 1; branchTarget = 32'h102;
    applyEdge();
    nVec++; if (pcOut !== 32'h102 || fault !== 1'b0) begin
      nErr++; $display("FAIL bad_redirect pcOut/fault got %h/%b want 00000102/0", pcOut, fault);
    end
    clearInputs();
    applyEdge();
    nVec++; if (fault !== 1'b1 || pcOut !== 32'h102 || ifidValid !== 1'b0) begin
      nErr++; $display("FAIL fault_raise got fault=%b pc=%h valid=%b want 1/00000102/0", fault, pcOut, ifidValid);
    end
    for (int i = 0; i < 6; i++) begin
      stall = 1'($urandom); flush = 1'($urandom); branchTaken = 1'($urandom);
      jump = 1'($urandom); branchTarget = 32'h20; jumpIndex = 26'h4;
      applyEdge();
      nVec++; if (fault !== 1'b1 || pcOut !== 32'h102 || ifidValid !== 1'b0) begin
        nErr++; $display("FAIL fault_hold%0d got fault=%b pc=%h valid=%b want 1/00000102/0", i, fault, pcOut, ifidValid);
      end
    end
    rst_n = 0;
    #1;
    nVec++; if (fault !== 1'b0 || pcOut !== 32'h0 || ifidValid !== 1'b0) begin
      nErr++; $display("FAIL fault_async_reset got fault=%b pc=%h valid=%b want 0/00000000/0", fault, pcOut, ifidValid);
    end
    doReset();
  endtask

  task automatic test_boundary();
    branchTaken = 1; branchTarget = 32'hFC;
    applyEdge();
    clearInputs();
    applyEdge();
    nVec++; if (ifidValid !== 1'b1 || ifidPcPlus4 !== 32'h100 || ifidInstr !== mem[63] || fault !== 1'b0) begin
      nErr++; $display("FAIL fetch_fc got valid=%b pc4=%h instr=%h fault=%b want 1/00000100/%h/0", ifidValid, ifidPcPlus4, ifidInstr, fault, mem[63]);
    end
    applyEdge();
    nVec++; if (fault !== 1'b1 || pcOut !== 32'h100) begin
      nErr++; $display("FAIL fetch_100 got fault=%b pc=%h want 1/00000100", fault, pcOut);
    end
    doReset();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) applyEdge();
    #2;
    rst_n = 0;
    #1;
    nVec++; if (pcOut !== 32'h0 || ifidInstr !== 32'h0 || ifidPcPlus4 !== 32'h0 || ifidValid !== 1'b0 || fault !== 1'b0) begin
      nErr++; $display("FAIL async_reset got %h/%h/%h/%b/%b want all zero", pcOut, ifidInstr, ifidPcPlus4, ifidValid, fault);
    end
    @(posedge clk);
    #1;
    nVec++; if (pcOut !== 32'h0 || ifidValid !== 1'b0) begin
      nErr++; $display("FAIL reset_held got pc=%h valid=%b want 00000000/0", pcOut, ifidValid);
    end
    doReset();
  endtask

  task automatic test_random();
    int unsigned faultCycles = 0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    doReset();
    for (int n = 0; n < 400; n++) begin
      branchTaken  = ($urandom_range(0, 7) == 0);
      jump         = ($urandom_range(0, 7) == 0);
      stall        = ($urandom_range(0, 3) == 0);
      flush        = ($urandom_range(0, 7) == 0);
      branchTarget = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 300)) : 32'($urandom_range(0, 63)) * 4;
      jumpIndex    = ($urandom_range(0, 9) == 0) ? 26'($urandom_range(64, 80)) : 26'($urandom_range(0, 63));
      applyEdge();
      nVec++; if (pcOut !== mPc) begin nErr++; $display("FAIL rand%0d pcOut got %h want %h", n, pcOut, mPc); end
      nVec++; if (ifidInstr !== mInstr || ifidPcPlus4 !== mPc4) begin
        nErr++; $display("FAIL rand%0d ifid got %h/%h want %h/%h", n, ifidInstr, ifidPcPlus4, mInstr, mPc4);
      end
      nVec++; if (ifidValid !== mValid || fault !== mFault) begin
        nErr++; $display("FAIL rand%0d valid/fault got %b/%b want %b/%b", n, ifidValid, fault, mValid, mFault);
      end
      faultCycles = mFault ? faultCycles + 1 : 0;
      if (faultCycles > 4) begin
        doReset();
        faultCycles = 0;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);
    mem[0] = 32'h2008_0001;
    mem[1] = 32'h2009_0002;
    test_reset();
    test_freerun();
    test_stall();
    test_branch();
    test_jump();
    test_fault();
    test_boundary();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
